// File: rtl/layer_seq_mult_signed16x2.sv
// Sequential signed WIDTH x WIDTH multiplier that reuses one external 2-bit
// partial-product layer, feeding it one radix-4 digit of B per cycle.
module layer_seq_mult_signed16x2 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [WIDTH-1:0]     layer_a,
    output logic                 layer_b_low,
    output logic                 layer_b_high,
    output logic                 layer_cin,
    input  logic [WIDTH+1:0]     layer_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NDIG = WIDTH / 2;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = 2 * WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic [KW-1:0]         k;
    logic [WIDTH-1:0]      a_reg, b_reg;
    logic signed [AW-1:0]  acc, acc_nxt, pp_ext;
    logic                  last_digit;
    logic                  accept;
    logic                  deliver;

    assign last_digit = (k == KW'(NDIG - 1));
    assign accept     = in_valid && (state == IDLE);
    assign deliver    = out_ready && (state == DONE);

    // The layer already applies the top digit's negative weight, so its result
    // is always a signed value and must be sign-extended before shifting.
    assign pp_ext  = {{WIDTH{layer_sum[WIDTH+1]}}, layer_sum};
    assign acc_nxt = acc + (pp_ext <<< {k, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = RUN;
            RUN:     if (last_digit) state_nxt = DONE;
            DONE:    if (deliver)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                a_reg <= a_in;
                b_reg <= b_in;
                acc   <= '0;
                k     <= '0;
            end else if (state == RUN) begin
                acc <= acc_nxt;
                k   <= k + 1'b1;
                if (last_digit) product <= acc_nxt[2*WIDTH-1:0];
            end
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign layer_a      = a_reg;
    assign layer_b_low  = (state == RUN) && b_reg[{k, 1'b0}];
    assign layer_b_high = (state == RUN) && b_reg[{k, 1'b1}];
    assign layer_cin    = 1'b0;

endmodule

// File: tb/tb_layer_seq_mult_signed16x2.sv
// Bench for layer_seq_mult_signed16x2: behavioural layer model, directed
// product table, handshake/stall/reset sequences and a random stream.
module tb_layer_seq_mult_signed16x2;

    localparam int W    = 16;
    localparam int NDIG = W / 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a_in = '0;
    logic [W-1:0]    b_in = '0;
    logic [W-1:0]    layer_a;
    logic            layer_b_low, layer_b_high, layer_cin;
    logic [W+1:0]    layer_sum;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  product;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    int xfer_exp = 0;

    layer_seq_mult_signed16x2 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .layer_a(layer_a), .layer_b_low(layer_b_low),
        .layer_b_high(layer_b_high), .layer_cin(layer_cin), .layer_sum(layer_sum),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    // Layer model: tracks which digit is presented from the accept handshake.
    int  run_cnt;
    bit  running;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            run_cnt <= 0;
        end else if (in_valid && in_ready) begin
            running <= 1'b1;
            run_cnt <= 0;
        end else if (running) begin
            if (run_cnt == NDIG - 1) running <= 1'b0;
            run_cnt <= run_cnt + 1;
        end
    end

    always_comb begin
        int d;
        int p;
        d = 0;
        p = 0;
        if (running && run_cnt == NDIG - 1)
            d = -2 * int'(layer_b_high) + int'(layer_b_low);
        else
            d = 2 * int'(layer_b_high) + int'(layer_b_low);
        p = int'($signed(layer_a)) * d + int'(layer_cin);
        layer_sum = p[W+1:0];
    end

    always @(posedge clk)
        if (rst_n && out_valid && out_ready) n_xfer++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction: accept, digit stream, latency, stall, transfer.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int stall, input bit pulse_in);
        int lat;
        logic [W-1:0] bv;
        lat = 0;
        while (!in_ready && lat < 40) begin @(negedge clk); lat++; end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
        bv = b;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat < NDIG) begin
                chk("digit", 64'({layer_b_high, layer_b_low}), 64'(bv[2*lat +: 2]));
                chk("layer_a", 64'(layer_a), 64'(a));
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(NDIG));
        chk("product", 64'(product), 64'(exp));
        chk("digits_idle", 64'({layer_b_high, layer_b_low}), 64'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = pulse_in;
            a_in = W'($urandom); b_in = W'($urandom);
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_product", 64'(product), 64'(exp));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1; xfer_exp++;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_xfer_valid", 64'(out_valid), 64'd0);
        chk("post_xfer_product", 64'(product), 64'(exp));
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{16'd3,      16'd5,      32'h0000_000F};
        vecs[1] = '{16'hFFFF,   16'hFFFF,   32'h0000_0001};
        vecs[2] = '{16'h8000,   16'h8000,   32'h4000_0000};
        vecs[3] = '{16'h7FFF,   16'h8000,   32'hC000_8000};
        vecs[4] = '{16'h7FFF,   16'h7FFF,   32'h3FFF_0001};
        vecs[5] = '{16'h8000,   16'h7FFF,   32'hC000_8000};
        vecs[6] = '{16'd0,      16'hABCD,   32'h0000_0000};
        vecs[7] = '{16'hFFFE,   16'd3,      32'hFFFF_FFFA};
        vecs[8] = '{16'd1,      16'h8000,   32'hFFFF_8000};
        vecs[9] = '{16'd1234,   16'hFFB3,   32'hFFFE_8CD6};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_layer", 64'({layer_a, layer_b_high, layer_b_low, layer_cin}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b0);

        // Output stall with ignored input pulses
        run_op(16'd3, 16'd5, 32'h0000_000F, 5, 1'b1);

        // Reset in the middle of digit 4
        while (!in_ready) @(negedge clk);
        a_in = 16'd1234; b_in = 16'hFFB3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_product", 64'(product), 64'd0);
        chk("mid_rst_layer", 64'({layer_a, layer_b_high, layer_b_low}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(16'd1234, 16'hFFB3, -32'sd95018, 1, 1'b0);

        // Random stream against a reference multiply
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra, rb;
            logic signed [2*W-1:0] rp;
            ra = W'($urandom);
            rb = W'($urandom);
            rp = $signed(ra) * $signed(rb);
            run_op(ra, rb, rp, int'($urandom_range(0, 3)), 1'(($urandom & 1)));
        end

        repeat (2) @(negedge clk);
        chk("xfer_count", 64'(n_xfer), 64'(xfer_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
